// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC gain compensator.
//
// Contents:
//   COEF_W      - width of the unsigned Q2.15 gain coefficients
//   KINV_Q15    - 1/K (0.607253) in Q2.15
//   K_Q15       - K   (1.646760) in Q2.15
//   FRAC_SHIFT  - fractional bits of the coefficients (result shift)
//   ROUND_BIAS  - half an LSB of the shifted result, for half-up rounding
//   gain_mode_e - per-sample gain selection
//   coef_sel()  - maps a gain mode to its coefficient
package cordic_pkg;

    localparam int COEF_W     = 17;
    localparam int FRAC_SHIFT = 15;
    localparam int ROUND_BIAS = 16384;

    localparam logic [COEF_W-1:0] KINV_Q15 = 17'd19899;
    localparam logic [COEF_W-1:0] K_Q15    = 17'd53961;

    typedef enum logic {
        GAIN_INV = 1'b0,
        GAIN_K   = 1'b1
    } gain_mode_e;

    function automatic logic [COEF_W-1:0] coef_sel(input gain_mode_e mode);
        return (mode == GAIN_K) ? K_Q15 : KINV_Q15;
    endfunction

endpackage

// File: rtl/cordic_gain_lane.sv
// One channel of the gain compensator: constant-coefficient multiply,
// pipelined partial-product accumulation, round half-up and saturate.
//
// Ports:
//   clock, reset  - clock and asynchronous active-high reset
//   en            - global stage enable; every register advances only when 1
//   in_v          - signed input sample (DATA_W bits)
//   mode_pipe     - gain mode per accumulation stage, owned by the top.
//                   With STAGES = 2 bit 0 is the mode of the incoming
//                   sample; otherwise bit j is the mode held alongside
//                   the sample sitting in v_q[j].
//   out_v         - rounded, saturated result (DATA_W bits)
//   out_sat       - result was clipped to the signed range
//
// Pipeline: stage 1 registers the sample, stages 2..STAGES-1 each add one
// slice of the coefficient's partial product, the last stage rounds and
// saturates. With STAGES = 2 the whole product is formed in stage 1.
module cordic_gain_lane
    import cordic_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int STAGES = 4,
    parameter int MP_W   = (STAGES > 2) ? STAGES - 2 : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [DATA_W-1:0] in_v,
    input  logic [MP_W-1:0]   mode_pipe,
    output logic [DATA_W-1:0] out_v,
    output logic              out_sat
);

    // Full signed product width: sample times coefficient with a zero sign bit.
    localparam int P_W  = DATA_W + COEF_W + 1;
    localparam int NACC = MP_W;
    // Coefficient (plus its zero sign bit) is cut into NACC equal slices.
    localparam int CH   = (COEF_W + 1 + NACC - 1) / NACC;
    localparam int CP_W = NACC * CH;

    localparam logic signed [P_W-1:0] RND  = P_W'(ROUND_BIAS);
    localparam logic signed [P_W-1:0] MAXV = P_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [P_W-1:0] MINV = -MAXV - P_W'(1);

    // Partial product of slice j of the mode's coefficient, already weighted.
    // Slices are unsigned, so each is widened with a zero sign bit. Any wrap
    // of an individual term cancels in the sum because the final product
    // always fits in P_W bits.
    function automatic logic signed [P_W-1:0] chunk_pp(
        input logic [DATA_W-1:0] v,
        input logic              mode,
        input int                j
    );
        logic [CP_W-1:0]        c;
        logic [CH-1:0]          slice;
        logic signed [P_W-1:0]  pp;
        c     = CP_W'(coef_sel(gain_mode_e'(mode)));
        slice = c[j*CH +: CH];
        pp    = P_W'($signed(v)) * P_W'($signed({1'b0, slice}));
        return pp <<< (j * CH);
    endfunction

    logic signed [P_W-1:0] acc_q [NACC];

    if (STAGES == 2) begin : g_short
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                acc_q[0] <= '0;
            end else if (en) begin
                acc_q[0] <= chunk_pp(in_v, mode_pipe[0], 0);
            end
        end
    end else begin : g_long
        logic [DATA_W-1:0] v_q [NACC];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int j = 0; j < NACC; j++) begin
                    v_q[j]   <= '0;
                    acc_q[j] <= '0;
                end
            end else if (en) begin
                v_q[0]   <= in_v;
                acc_q[0] <= chunk_pp(v_q[0], mode_pipe[0], 0);
                for (int j = 1; j < NACC; j++) begin
                    v_q[j]   <= v_q[j-1];
                    acc_q[j] <= acc_q[j-1] + chunk_pp(v_q[j], mode_pipe[j], j);
                end
            end
        end
    end

    logic signed [P_W-1:0] biased;
    logic signed [P_W-1:0] r_full;

    // Arithmetic shift after adding half an LSB: ties round toward +inf.
    assign biased = acc_q[NACC-1] + RND;
    assign r_full = biased >>> FRAC_SHIFT;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_v   <= '0;
            out_sat <= 1'b0;
        end else if (en) begin
            if (r_full > MAXV) begin
                out_v   <= MAXV[DATA_W-1:0];
                out_sat <= 1'b1;
            end else if (r_full < MINV) begin
                out_v   <= MINV[DATA_W-1:0];
                out_sat <= 1'b1;
            end else begin
                out_v   <= r_full[DATA_W-1:0];
                out_sat <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cordic_gain_comp.sv
// Dual-channel CORDIC gain compensator: scales (x, y) by 1/K or K per
// sample with bit-exact rounding and saturation, STAGES cycles of latency.
//
// Ports:
//   clock, reset         - clock and asynchronous active-high reset
//   in_valid / in_ready  - input handshake
//   in_x, in_y           - signed samples
//   in_mode              - 0: multiply by 1/K, 1: multiply by K
//   in_id                - tag carried alongside the sample
//   out_valid / out_ready- output handshake
//   out_x, out_y         - scaled samples
//   out_id               - tag of the output sample
//   out_sat              - bit0 x saturated, bit1 y saturated
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The whole pipe moves as one (en); it stalls only when the last
// stage holds a sample that downstream refuses, so in_ready = en and the
// output registers hold steady for as long as out_valid && !out_ready.
// Empty slots travel with the data and are never squeezed out.
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int FRAC_W   = 8,
    parameter int ID_WIDTH = 8,
    parameter int STAGES   = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_x,
    input  logic [DATA_W-1:0]   in_y,
    input  logic                in_mode,
    input  logic [ID_WIDTH-1:0] in_id,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_x,
    output logic [DATA_W-1:0]   out_y,
    output logic [ID_WIDTH-1:0] out_id,
    output logic [1:0]          out_sat
);

    localparam int MP_W = (STAGES > 2) ? STAGES - 2 : 1;

    // FRAC_W only documents the sample format; the datapath preserves it.
    if (STAGES < 2 || STAGES > 10) begin : g_bad_stages
        $error("cordic_gain_comp: STAGES must be within 2..10");
    end
    if (FRAC_W < 0 || FRAC_W >= DATA_W) begin : g_bad_frac
        $error("cordic_gain_comp: FRAC_W must be within 0..DATA_W-1");
    end

    logic                en;
    logic [STAGES-1:0]   valid_q;
    logic [ID_WIDTH-1:0] id_q [STAGES];
    logic [MP_W-1:0]     lane_mode;
    logic                sat_x;
    logic                sat_y;

    assign en        = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = valid_q[STAGES-1];
    assign out_id    = id_q[STAGES-1];
    assign out_sat   = {sat_y, sat_x};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                id_q[i] <= '0;
            end
        end else if (en) begin
            valid_q <= {valid_q[STAGES-2:0], in_valid};
            id_q[0] <= in_id;
            for (int i = 1; i < STAGES; i++) begin
                id_q[i] <= id_q[i-1];
            end
        end
    end

    // Mode rides alongside the sample through the accumulation stages so
    // every slice of the product uses the coefficient its sample asked for.
    if (STAGES == 2) begin : g_mode_direct
        assign lane_mode = in_mode;
    end else begin : g_mode_pipe
        logic [MP_W-1:0] mode_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                mode_q <= '0;
            end else if (en) begin
                mode_q[0] <= in_mode;
                for (int i = 1; i < MP_W; i++) begin
                    mode_q[i] <= mode_q[i-1];
                end
            end
        end

        assign lane_mode = mode_q;
    end

    cordic_gain_lane #(
        .DATA_W (DATA_W),
        .STAGES (STAGES),
        .MP_W   (MP_W)
    ) u_lane_x (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .in_v      (in_x),
        .mode_pipe (lane_mode),
        .out_v     (out_x),
        .out_sat   (sat_x)
    );

    cordic_gain_lane #(
        .DATA_W (DATA_W),
        .STAGES (STAGES),
        .MP_W   (MP_W)
    ) u_lane_y (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .in_v      (in_y),
        .mode_pipe (lane_mode),
        .out_v     (out_y),
        .out_sat   (sat_y)
    );

endmodule
